spi_reg_bank: RTL

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_reg_bank.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared FSM states and frame-length helper for the SPI register bank
package spi_reg_pkg;

   // Frame phases: waiting for select, address phase, data phase, frame complete.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ADDR    = 2'd1,
      ST_DATA    = 2'd2,
      ST_WAIT_CS = 2'd3
   } spi_state_e;

   // One R/W bit, then the address field, then the data field.
   function automatic int frame_len(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rising/falling edge detect
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
)(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the async pin through the chain; keep one extra flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 slave register bank with write commit on deselect
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = 5,
   parameter int SYNC_STAGES = 2
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk,
   input  logic                       copi,
   input  logic                       ncs,
   output logic                       cipo,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs,
   output logic                       wr_pulse,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       addr_err
);

   localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);

   spi_state_e             state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt;
   logic [FRAME_LEN-1:0]   frame_sr;
   logic [DATA_W-1:0]      dout_sr;
   logic [DATA_W-1:0]      regs_q [NUM_REGS];
   logic [DATA_W-1:0]      rd_word;
   logic                   rd_active;
   logic                   cap_pend;
   logic                   sample;

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic copi_lvl, copi_rise, copi_fall;
   logic ncs_lvl,  ncs_rise,  ncs_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .din(copi),
      .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .din(ncs),
      .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
   );

   logic unused_edges;
   assign unused_edges = &{1'b0, sclk_lvl, copi_rise, copi_fall};

   // Decoded frame fields: full frame view and the view right after the address phase.
   logic              fr_rw, cap_rw;
   logic [ADDR_W-1:0] fr_addr, cap_addr;
   logic [DATA_W-1:0] fr_data;
   assign fr_rw    = frame_sr[FRAME_LEN-1];
   assign fr_addr  = frame_sr[DATA_W +: ADDR_W];
   assign fr_data  = frame_sr[DATA_W-1:0];
   assign cap_rw   = frame_sr[ADDR_W];
   assign cap_addr = frame_sr[ADDR_W-1:0];

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS));
   endfunction

   logic commit, commit_ok, capture, shift_out;
   assign commit    = ncs_rise & (state_q == ST_WAIT_CS) & fr_rw;
   assign commit_ok = commit & in_range(fr_addr);
   assign capture   = cap_pend & (state_q == ST_DATA) & ~cap_rw;
   // The falling edge that closes the last address clock must not shift: the MSB is
   // only consumed by the master on the first data-phase rising edge.
   assign shift_out = sclk_fall & (state_q == ST_DATA) & rd_active
                    & (bit_cnt > CNT_W'(ADDR_W + 1));

   // Register file read port for the read capture.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (cap_addr == ADDR_W'(i)) rd_word = regs_q[i];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state and bit-sample enable; select edges take priority over sclk.
   always_comb begin
      state_d = state_q;
      sample  = 1'b0;
      if (ncs_rise) begin
         state_d = ST_IDLE;
      end else if (ncs_fall) begin
         state_d = ST_ADDR;
      end else begin
         case (state_q)
            ST_ADDR: if (sclk_rise && !ncs_lvl) begin
               sample = 1'b1;
               if (bit_cnt == CNT_W'(ADDR_W)) state_d = ST_DATA;
            end
            ST_DATA: if (sclk_rise && !ncs_lvl) begin
               sample = 1'b1;
               if (bit_cnt == CNT_W'(FRAME_LEN - 1)) state_d = ST_WAIT_CS;
            end
            default: ;
         endcase
      end
   end

   // Frame shifter, read shifter and strobe generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         frame_sr  <= '0;
         dout_sr   <= '0;
         rd_active <= 1'b0;
         cap_pend  <= 1'b0;
         wr_pulse  <= 1'b0;
         wr_addr   <= '0;
         addr_err  <= 1'b0;
      end else begin
         wr_pulse <= 1'b0;
         addr_err <= 1'b0;
         cap_pend <= 1'b0;
         if (ncs_fall) begin
            bit_cnt   <= '0;
            frame_sr  <= '0;
            dout_sr   <= '0;
            rd_active <= 1'b0;
         end else if (sample) begin
            frame_sr <= {frame_sr[FRAME_LEN-2:0], copi_lvl};
            bit_cnt  <= bit_cnt + 1'b1;
            cap_pend <= (state_q == ST_ADDR) && (bit_cnt == CNT_W'(ADDR_W));
         end
         if (capture) begin
            rd_active <= 1'b1;
            if (in_range(cap_addr)) begin
               dout_sr <= rd_word;
            end else begin
               dout_sr  <= '0;
               addr_err <= 1'b1;
            end
         end else if (shift_out) begin
            dout_sr <= {dout_sr[DATA_W-2:0], 1'b0};
         end
         if (commit_ok) begin
            wr_pulse <= 1'b1;
            wr_addr  <= fr_addr;
         end else if (commit) begin
            addr_err <= 1'b1;
         end
      end
   end

   // Register storage, written only by a committed in-range write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_ok && fr_addr == ADDR_W'(i)) regs_q[i] <= fr_data;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign cipo    = (state_q == ST_DATA) & rd_active & dout_sr[DATA_W-1];
   assign cipo_oe = ~ncs_lvl;

endmodule
